// File: rtl/traffic_pkg.sv
// traffic_pkg: light codes, fault causes, monitor states and tick-count helper shared by the lamp monitor
package traffic_pkg;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] FC_NONE = 3'd0;
  localparam logic [2:0] FC_ILLEGAL = 3'd1;
  localparam logic [2:0] FC_CONFLICT = 3'd2;
  localparam logic [2:0] FC_G2R = 3'd3;
  localparam logic [2:0] FC_SHORT_YEL = 3'd4;
  localparam logic [2:0] FC_WDOG = 3'd5;
  typedef enum logic [1:0] {INIT, RUN, FAULT, RECOVER} state_t;
  function automatic logic tick_done(input logic [7:0] cnt, input logic [7:0] lim);
    return ({1'b0, cnt} + 9'd1) >= {1'b0, lim};
  endfunction
endpackage

// File: rtl/lamp_channel_check.sv
// lamp_channel_check: per-approach one-hot, green-to-red and minimum-yellow checks
module lamp_channel_check
  import traffic_pkg::*;
#(
  parameter int MIN_YEL_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       clr,
  input  logic [2:0] cur,
  input  logic [2:0] prev,
  output logic       illegal,
  output logic       g2r,
  output logic       short_yel,
  output logic       not_red
);
  logic [7:0] ycnt;
  logic       ok;
  logic       entry;
  assign entry = (cur == YEL) && (prev != YEL);
  // ok marks a yellow that began outside RUN, so its length is not judged
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ycnt <= '0;
      ok <= 1'b0;
    end else if (clr) begin
      ycnt <= '0;
      ok <= 1'b1;
    end else if (entry) begin
      ycnt <= {7'd0, tick};
      ok <= 1'b0;
    end else if (cur == YEL && tick && ycnt != 8'hff) begin
      ycnt <= ycnt + 8'd1;
    end
  assign illegal = !$onehot(cur);
  assign g2r = (prev == GRN) && (cur == RED);
  assign short_yel = !ok && (prev == YEL) && (cur != YEL) && (ycnt < 8'(MIN_YEL_TICKS));
  assign not_red = cur != RED;
endmodule

// File: rtl/traffic_lamp_monitor.sv
// traffic_lamp_monitor: checks controller light codes, drives lamps, flashes red on faults; TRAFFIC_LAMP_MONITOR_WDOG_EN adds a stuck-input watchdog
module traffic_lamp_monitor
  import traffic_pkg::*;
#(
  parameter int INIT_TICKS    = 4,
  parameter int FLASH_TICKS   = 1,
  parameter int ALLRED_TICKS  = 3,
  parameter int MIN_YEL_TICKS = 2,
  parameter int WDOG_TICKS    = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [2:0] light_m1,
  input  logic [2:0] light_m2,
  input  logic [2:0] light_mT,
  input  logic [2:0] light_s,
  input  logic       fault_clr,
  output logic [2:0] lamp_m1,
  output logic [2:0] lamp_m2,
  output logic [2:0] lamp_mT,
  output logic [2:0] lamp_s,
  output logic       fault,
  output logic [2:0] fault_code
);
  state_t          state, state_d;
  logic [7:0]      cnt, cnt_d, cnt_inc;
  logic            phase, phase_d;
  logic [2:0]      code_d, hit_code;
  logic [3:0][2:0] in_codes, cur, prev, lamp, lamp_d;
  logic [3:0]      illegal, g2r, short_yel, not_red;
  logic            conflict, fault_hit, wdog_hit;
  assign in_codes = {light_s, light_mT, light_m2, light_m1};
  for (genvar i = 0; i < 4; i++) begin : g_ch
    lamp_channel_check #(.MIN_YEL_TICKS(MIN_YEL_TICKS)) u_chk (
      .clk(clk),
      .reset(reset),
      .tick(tick),
      .clr(state != RUN),
      .cur(cur[i]),
      .prev(prev[i]),
      .illegal(illegal[i]),
      .g2r(g2r[i]),
      .short_yel(short_yel[i]),
      .not_red(not_red[i])
    );
  end
`ifdef TRAFFIC_LAMP_MONITOR_WDOG_EN
  logic [7:0] wcnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) wcnt <= '0;
    else if (state != RUN || cur != prev) wcnt <= '0;
    else if (tick && wcnt != 8'hff) wcnt <= wcnt + 8'd1;
  assign wdog_hit = wcnt >= 8'(WDOG_TICKS);
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_TICKS;
  assign wdog_hit = 1'b0;
`endif
  assign conflict = (not_red[3] && |not_red[2:0]) || (not_red[1] && not_red[2]);
  assign hit_code = |illegal ? FC_ILLEGAL : conflict ? FC_CONFLICT : |g2r ? FC_G2R :
                    |short_yel ? FC_SHORT_YEL : wdog_hit ? FC_WDOG : FC_NONE;
  assign fault_hit = (state == RUN) && (hit_code != FC_NONE);
  assign cnt_inc = cnt + 8'd1;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    phase_d = phase;
    code_d = fault_code;
    case (state)
      INIT: if (tick) begin
        cnt_d = tick_done(cnt, 8'(INIT_TICKS)) ? 8'd0 : cnt_inc;
        state_d = tick_done(cnt, 8'(INIT_TICKS)) ? RUN : INIT;
      end
      RUN: if (fault_hit) begin
        state_d = FAULT;
        cnt_d = '0;
        phase_d = 1'b1;
        code_d = hit_code;
      end
      FAULT: if (fault_clr) begin
        state_d = RECOVER;
        cnt_d = '0;
      end else if (tick) begin
        cnt_d = tick_done(cnt, 8'(FLASH_TICKS)) ? 8'd0 : cnt_inc;
        phase_d = tick_done(cnt, 8'(FLASH_TICKS)) ? ~phase : phase;
      end
      RECOVER: if (tick) begin
        cnt_d = tick_done(cnt, 8'(ALLRED_TICKS)) ? 8'd0 : cnt_inc;
        state_d = tick_done(cnt, 8'(ALLRED_TICKS)) ? RUN : RECOVER;
        code_d = tick_done(cnt, 8'(ALLRED_TICKS)) ? FC_NONE : fault_code;
      end
      default: state_d = INIT;
    endcase
  end
  // cur is only shown once it has been checked in RUN, so no unchecked pattern reaches a lamp
  assign lamp_d = (state_d == FAULT) ? {4{phase_d, 2'b00}} :
                  (state == RUN && state_d == RUN) ? cur : {4{RED}};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= INIT;
      cnt <= '0;
      phase <= 1'b1;
      fault_code <= FC_NONE;
      cur <= {4{RED}};
      prev <= {4{RED}};
      lamp <= {4{RED}};
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      phase <= phase_d;
      fault_code <= code_d;
      cur <= in_codes;
      prev <= cur;
      lamp <= lamp_d;
    end
  assign fault = (state == FAULT) || (state == RECOVER);
  assign {lamp_s, lamp_mT, lamp_m2, lamp_m1} = lamp;
endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// tb_traffic_lamp_monitor: directed vectors for traffic_lamp_monitor with a tick every 4 clk
module tb_traffic_lamp_monitor;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [11:0] ALLR = {R, R, R, R};
  localparam logic [11:0] OFF = 12'h000;
  localparam logic [11:0] BASE = {R, R, R, G};
  localparam logic [11:0] SEQ [11] = '{
    {R, R, G, G}, {R, R, Y, G}, {R, R, R, G}, {R, G, R, G}, {R, Y, R, G}, {R, R, R, G},
    {R, R, R, Y}, {R, R, R, R}, {G, R, R, R}, {Y, R, R, R}, {R, R, R, R}
  };
  logic clk = 1'b0;
  logic reset, tick, fault_clr, fault;
  logic [2:0] light_m1, light_m2, light_mT, light_s;
  logic [2:0] lamp_m1, lamp_m2, lamp_mT, lamp_s, fault_code;
  logic [11:0] lamps;
  int nvec = 0;
  int nerr = 0;
  int ncyc = 0;
  traffic_lamp_monitor dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .light_m1(light_m1),
    .light_m2(light_m2),
    .light_mT(light_mT),
    .light_s(light_s),
    .fault_clr(fault_clr),
    .lamp_m1(lamp_m1),
    .lamp_m2(lamp_m2),
    .lamp_mT(lamp_mT),
    .lamp_s(lamp_s),
    .fault(fault),
    .fault_code(fault_code)
  );
  assign lamps = {lamp_s, lamp_mT, lamp_m2, lamp_m1};
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      tick = (ncyc % 4 == 0);
      ncyc++;
      @(posedge clk);
      #1;
    end
    tick = 1'b0;
  endtask
  task automatic align();
    while (ncyc % 4 != 0) cyc(1);
  endtask
  task automatic setv(input logic [11:0] v);
    {light_s, light_mT, light_m2, light_m1} = v;
  endtask
  task automatic recover();
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    for (int i = 0; i < 40 && fault; i++) cyc(1);
    check("recover_done", 12'(fault), 12'd0);
    cyc(2);
    check("recover_lamps", lamps, BASE);
  endtask
  initial begin
    reset = 1'b1;
    tick = 1'b0;
    fault_clr = 1'b0;
    setv(BASE);
    repeat (2) @(posedge clk);
    #1;
    check("rst_lamps", lamps, ALLR);
    check("rst_fault", 12'(fault), 12'd0);
    check("rst_code", 12'(fault_code), 12'd0);
    reset = 1'b0;
    ncyc = 0;
    cyc(12);
    check("init_3ticks_lamps", lamps, ALLR);
    check("init_3ticks_fault", 12'(fault), 12'd0);
    cyc(1);
    check("init_4ticks_lamps", lamps, ALLR);
    cyc(1);
    check("run_first_lamps", lamps, BASE);
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 11; k++) begin
        setv(SEQ[k]);
        cyc(2);
        check("seq_lamps", lamps, SEQ[k]);
        check("seq_fault", 12'(fault), 12'd0);
        cyc(6);
      end
    setv(BASE);
    cyc(8);
    align();
    setv({G, R, R, G});
    cyc(2);
    check("conflict_fault", 12'(fault), 12'd1);
    check("conflict_code", 12'(fault_code), 12'd2);
    check("conflict_lamps", lamps, ALLR);
    setv(BASE);
    cyc(2);
    check("flash_hold", lamps, ALLR);
    cyc(1);
    check("flash_off", lamps, OFF);
    cyc(4);
    check("flash_on", lamps, ALLR);
    align();
    cyc(1);
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    check("recover_fault", 12'(fault), 12'd1);
    check("recover_lamps_red", lamps, ALLR);
    check("recover_code", 12'(fault_code), 12'd2);
    cyc(10);
    check("recover_2ticks_fault", 12'(fault), 12'd1);
    check("recover_2ticks_lamps", lamps, ALLR);
    cyc(1);
    check("rerun_fault", 12'(fault), 12'd0);
    check("rerun_code", 12'(fault_code), 12'd0);
    check("rerun_lamps_red", lamps, ALLR);
    cyc(1);
    check("rerun_lamps", lamps, BASE);
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    cyc(2);
    check("clr_in_run_fault", 12'(fault), 12'd0);
    check("clr_in_run_lamps", lamps, BASE);
    setv({R, R, G, G});
    cyc(8);
    setv(BASE);
    cyc(2);
    check("g2r_fault", 12'(fault), 12'd1);
    check("g2r_code", 12'(fault_code), 12'd3);
    check("g2r_lamps", lamps, ALLR);
    recover();
    setv({R, R, G, G});
    cyc(8);
    setv({R, R, Y, G});
    cyc(4);
    setv(BASE);
    cyc(2);
    check("short_yel_code", 12'(fault_code), 12'd4);
    setv(BASE);
    recover();
    setv({G, 3'b011, R, G});
    cyc(2);
    check("priority_code", 12'(fault_code), 12'd1);
    setv(BASE);
    recover();
`ifdef TRAFFIC_LAMP_MONITOR_WDOG_EN
    cyc(120);
    check("wdog_early", 12'(fault), 12'd0);
    for (int i = 0; i < 80 && !fault; i++) cyc(1);
    check("wdog_fault", 12'(fault), 12'd1);
    check("wdog_code", 12'(fault_code), 12'd5);
`else
    cyc(400);
    check("no_wdog_fault", 12'(fault), 12'd0);
    check("no_wdog_code", 12'(fault_code), 12'd0);
`endif
    setv({G, R, R, G});
    cyc(2);
    check("pre_reset_fault", 12'(fault), 12'd1);
    reset = 1'b1;
    #2;
    check("midrst_lamps", lamps, ALLR);
    check("midrst_fault", 12'(fault), 12'd0);
    check("midrst_code", 12'(fault_code), 12'd0);
    reset = 1'b0;
    cyc(3);
    check("post_rst_lamps", lamps, ALLR);
    check("post_rst_fault", 12'(fault), 12'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
